// File: rtl/bridge_fc_monitor_if.sv
// Status and flow-control bundle between the PCIe core fc/status port and the
// bridge control block. Everything here is level-sampled status with no handshake.
interface bridge_fc_monitor_if #(
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12
);
    logic              Ctrl_Link_Up;
    logic [HDR_W-1:0]  Ctrl_fc_ph;
    logic [DATA_W-1:0] Ctrl_fc_pd;
    logic [HDR_W-1:0]  Ctrl_fc_nph;
    logic [DATA_W-1:0] Ctrl_fc_npd;
    logic [HDR_W-1:0]  Ctrl_fc_cplh;
    logic [DATA_W-1:0] Ctrl_fc_cpld;
    logic [2:0]        Ctrl_fc_sel;
    logic              Ctrl_Bridge_RST;
    logic              Ctrl_Bridge_Ready;
    logic [5:0]        Ctrl_Tx_FC;
    logic [5:0]        Ctrl_Stall;
    logic [1:0]        dbg_state;

    modport slave (
        input  Ctrl_Link_Up, Ctrl_fc_ph, Ctrl_fc_pd, Ctrl_fc_nph,
               Ctrl_fc_npd, Ctrl_fc_cplh, Ctrl_fc_cpld,
        output Ctrl_fc_sel, Ctrl_Bridge_RST, Ctrl_Bridge_Ready,
               Ctrl_Tx_FC, Ctrl_Stall, dbg_state
    );

    modport master (
        output Ctrl_Link_Up, Ctrl_fc_ph, Ctrl_fc_pd, Ctrl_fc_nph,
               Ctrl_fc_npd, Ctrl_fc_cplh, Ctrl_fc_cpld,
        input  Ctrl_fc_sel, Ctrl_Bridge_RST, Ctrl_Bridge_Ready,
               Ctrl_Tx_FC, Ctrl_Stall, dbg_state
    );
endinterface

// File: rtl/bridge_fc_monitor.sv
// Bridge bring-up sequencer plus credit-to-permit hysteresis and per-channel
// credit starvation monitor.
module bridge_fc_monitor #(
    parameter int HDR_W         = 8,
    parameter int DATA_W        = 12,
    parameter int HDR_HI        = 8,
    parameter int HDR_LO        = 4,
    parameter int DATA_HI       = 32,
    parameter int DATA_LO       = 16,
    parameter int SETTLE_CYCLES = 16,
    parameter int STALL_LIMIT   = 1024,
    parameter int STALL_W       = 11
) (
    input logic           Ctrl_CLK,
    input logic           Ctrl_RST,
    bridge_fc_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        RST_S     = 2'd0,
        WAIT_LINK = 2'd1,
        SETTLE    = 2'd2,
        READY     = 2'd3
    } state_t;

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [HDR_W-1:0]   HDR_HI_V  = HDR_W'(HDR_HI);
    localparam logic [HDR_W-1:0]   HDR_LO_V  = HDR_W'(HDR_LO);
    localparam logic [DATA_W-1:0]  DATA_HI_V = DATA_W'(DATA_HI);
    localparam logic [DATA_W-1:0]  DATA_LO_V = DATA_W'(DATA_LO);
    localparam logic [SET_W-1:0]   SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [STALL_W-1:0] LIMIT_V   = STALL_W'(STALL_LIMIT);

    state_t             state, state_nxt;
    logic [SET_W-1:0]   settle_cnt, settle_cnt_nxt;
    logic               link_q;
    logic [HDR_W-1:0]   ph_q, nph_q, cplh_q;
    logic [DATA_W-1:0]  pd_q, npd_q, cpld_q;
    logic               bridge_rst_q, ready_q;
    logic [5:0]         tx_fc_q;
    logic [STALL_W-1:0] stall_cnt [6];
    logic [5:0]         stall_flag;

    function automatic logic hyst_h(input logic [HDR_W-1:0] c, input logic old);
        if (c >= HDR_HI_V) return 1'b1;
        if (c < HDR_LO_V)  return 1'b0;
        return old;
    endfunction

    function automatic logic hyst_d(input logic [DATA_W-1:0] c, input logic old);
        if (c >= DATA_HI_V) return 1'b1;
        if (c < DATA_LO_V)  return 1'b0;
        return old;
    endfunction

    // Stage 1: register link status and all credit inputs.
    always_ff @(posedge Ctrl_CLK) begin
        if (Ctrl_RST) begin
            link_q <= 1'b0;
            ph_q   <= '0;
            pd_q   <= '0;
            nph_q  <= '0;
            npd_q  <= '0;
            cplh_q <= '0;
            cpld_q <= '0;
        end else begin
            link_q <= bus.Ctrl_Link_Up;
            ph_q   <= bus.Ctrl_fc_ph;
            pd_q   <= bus.Ctrl_fc_pd;
            nph_q  <= bus.Ctrl_fc_nph;
            npd_q  <= bus.Ctrl_fc_npd;
            cplh_q <= bus.Ctrl_fc_cplh;
            cpld_q <= bus.Ctrl_fc_cpld;
        end
    end

    always_ff @(posedge Ctrl_CLK) begin
        if (Ctrl_RST) begin
            state      <= RST_S;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    // Losing the link beats settle completion so a flapping link never reaches READY.
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        case (state)
            RST_S: state_nxt = WAIT_LINK;
            WAIT_LINK: begin
                if (link_q) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = '0;
                end
            end
            SETTLE: begin
                if (!link_q) begin
                    state_nxt = WAIT_LINK;
                end else if (settle_cnt == SET_LAST) begin
                    state_nxt = READY;
                end else begin
                    settle_cnt_nxt = settle_cnt + 1'b1;
                end
            end
            READY: begin
                if (!link_q) state_nxt = WAIT_LINK;
            end
            default: state_nxt = RST_S;
        endcase
    end

    always_ff @(posedge Ctrl_CLK) begin
        if (Ctrl_RST) begin
            bridge_rst_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            bridge_rst_q <= (state_nxt == SETTLE) || (state_nxt == READY);
            ready_q      <= (state_nxt == READY);
        end
    end

    // The permit register doubles as hysteresis state, so leaving READY wipes it.
    always_ff @(posedge Ctrl_CLK) begin
        if (Ctrl_RST || state_nxt != READY) begin
            tx_fc_q <= '0;
        end else begin
            tx_fc_q <= {hyst_d(cpld_q, tx_fc_q[5]), hyst_h(cplh_q, tx_fc_q[4]),
                        hyst_d(npd_q,  tx_fc_q[3]), hyst_h(nph_q,  tx_fc_q[2]),
                        hyst_d(pd_q,   tx_fc_q[1]), hyst_h(ph_q,   tx_fc_q[0])};
        end
    end

    for (genvar i = 0; i < 6; i++) begin : g_stall
        always_ff @(posedge Ctrl_CLK) begin
            if (Ctrl_RST || state_nxt != READY || tx_fc_q[i]) begin
                stall_cnt[i] <= '0;
            end else if (state == READY && stall_cnt[i] != LIMIT_V) begin
                stall_cnt[i] <= stall_cnt[i] + 1'b1;
            end
        end
        assign stall_flag[i] = (stall_cnt[i] == LIMIT_V);
    end

    assign bus.Ctrl_fc_sel       = 3'b100;
    assign bus.Ctrl_Bridge_RST   = bridge_rst_q;
    assign bus.Ctrl_Bridge_Ready = ready_q;
    assign bus.Ctrl_Tx_FC        = tx_fc_q;
    assign bus.Ctrl_Stall        = stall_flag;
    assign bus.dbg_state         = state;

endmodule
